// File: rtl/can_transmitter.sv
// CAN 2.0A standard-frame transmitter: serializes one frame per request, one bit per baud_clk,
// with bit stuffing over SOF..CRC, CRC-15 generation and ACK-slot monitoring.
module can_transmitter #(
    parameter int unsigned IFS_BITS = 3
) (
    input  logic        baud_clk,
    input  logic        reset,
    input  logic        tx_start,
    input  logic [10:0] tx_id,
    input  logic        tx_rtr,
    input  logic [3:0]  tx_dlc,
    input  logic [63:0] tx_data,
    input  logic        CAN_RX,
    output logic        CAN_TX,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        ack_err
);

    localparam int unsigned ID_W   = 11;
    localparam int unsigned DLC_W  = 4;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned CRC_W  = 15;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned RUN_W  = 3;
    localparam int unsigned NB_W   = 7;
    localparam int unsigned EOF_BITS = 7;
    localparam logic [CRC_W-1:0] CRC_POLY = 15'h4599;

    typedef enum logic [3:0] {
        S_IDLE, S_SOF, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC,
        S_CRC_DELIM, S_ACK_SLOT, S_ACK_DELIM, S_EOF, S_IFS
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                rtr_q, rtr_d;
    logic [DLC_W-1:0]    dlc_q, dlc_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [NB_W-1:0]     nbits_q, nbits_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic                tx_d, busy_d, done_d, ack_err_d;
    logic                in_region, adv;

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc, input logic b);
        logic [CRC_W-1:0] c;
        c = {crc[CRC_W-2:0], 1'b0};
        if (b ^ crc[CRC_W-1]) c = c ^ CRC_POLY;
        return c;
    endfunction

    // state/cnt name the field of the most recent non-stuff bit; a stuff bit holds them
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        rtr_d     = rtr_q;
        dlc_d     = dlc_q;
        data_d    = data_q;
        nbits_d   = nbits_q;
        crc_d     = crc_q;
        run_d     = run_q;
        tx_d      = CAN_TX;
        busy_d    = tx_busy;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        adv       = 1'b0;
        in_region = state_q inside {S_SOF, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC};

        if (state_q == S_IDLE) begin
            tx_d = 1'b1;
            if (tx_start) begin
                state_d = S_SOF;
                cnt_d   = '0;
                id_d    = tx_id;
                rtr_d   = tx_rtr;
                dlc_d   = tx_dlc;
                data_d  = tx_data;
                nbits_d = tx_rtr ? '0 : ((tx_dlc > 4'd8) ? NB_W'(64) : NB_W'({tx_dlc, 3'b000}));
                crc_d   = '0;
                run_d   = RUN_W'(1);
                tx_d    = 1'b0;
                busy_d  = 1'b1;
            end
        end else if (in_region && run_q == RUN_W'(5)) begin
            tx_d  = ~CAN_TX;
            run_d = RUN_W'(1);
        end else begin
            adv = 1'b1;
        end

        if (adv) begin
            cnt_d = '0;
            case (state_q)
                S_SOF:       state_d = S_ID;
                S_ID:        if (cnt_q == CNT_W'(ID_W - 1)) state_d = S_RTR;
                             else cnt_d = cnt_q + CNT_W'(1);
                S_RTR:       state_d = S_IDE;
                S_IDE:       state_d = S_R0;
                S_R0:        state_d = S_DLC;
                S_DLC:       if (cnt_q == CNT_W'(DLC_W - 1))
                                 state_d = (nbits_q == '0) ? S_CRC : S_DATA;
                             else cnt_d = cnt_q + CNT_W'(1);
                S_DATA:      if (cnt_q + CNT_W'(1) == CNT_W'(nbits_q)) state_d = S_CRC;
                             else cnt_d = cnt_q + CNT_W'(1);
                S_CRC:       if (cnt_q == CNT_W'(CRC_W - 1)) state_d = S_CRC_DELIM;
                             else cnt_d = cnt_q + CNT_W'(1);
                S_CRC_DELIM: state_d = S_ACK_SLOT;
                S_ACK_SLOT: begin
                    state_d   = S_ACK_DELIM;
                    ack_err_d = CAN_RX;
                end
                S_ACK_DELIM: state_d = S_EOF;
                S_EOF:       if (cnt_q == CNT_W'(EOF_BITS - 1)) state_d = S_IFS;
                             else cnt_d = cnt_q + CNT_W'(1);
                S_IFS: begin
                    if (cnt_q == CNT_W'(IFS_BITS - 1)) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default:     state_d = S_IDLE;
            endcase

            case (state_d)
                S_ID:    tx_d = id_q[4'd10 - cnt_d[3:0]];
                S_RTR:   tx_d = rtr_q;
                S_IDE:   tx_d = 1'b0;
                S_R0:    tx_d = 1'b0;
                S_DLC:   tx_d = dlc_q[2'd3 - cnt_d[1:0]];
                S_DATA:  tx_d = data_q[6'd63 - cnt_d[5:0]];
                S_CRC:   tx_d = crc_q[4'd14 - cnt_d[3:0]];
                default: tx_d = 1'b1;
            endcase

            if (state_d inside {S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA})
                crc_d = crc_step(crc_q, tx_d);
            if (in_region)
                run_d = (tx_d == CAN_TX) ? run_q + RUN_W'(1) : RUN_W'(1);
        end
    end

    always_ff @(posedge baud_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
            rtr_q   <= 1'b0;
            dlc_q   <= '0;
            data_q  <= '0;
            nbits_q <= '0;
            crc_q   <= '0;
            run_q   <= '0;
            CAN_TX  <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            rtr_q   <= rtr_d;
            dlc_q   <= dlc_d;
            data_q  <= data_d;
            nbits_q <= nbits_d;
            crc_q   <= crc_d;
            run_q   <= run_d;
            CAN_TX  <= tx_d;
            tx_busy <= busy_d;
            tx_done <= done_d;
            ack_err <= ack_err_d;
        end
    end

endmodule

// File: tb/tb_can_transmitter.sv
// Scoreboard bench for can_transmitter: a list-based golden model builds the stuffed bit stream,
// which is popped and compared against CAN_TX cycle by cycle.
module tb_can_transmitter;

    localparam int unsigned IFS_BITS = 3;

    logic        baud_clk = 1'b0;
    logic        reset    = 1'b1;
    logic        tx_start = 1'b0;
    logic [10:0] tx_id    = '0;
    logic        tx_rtr   = 1'b0;
    logic [3:0]  tx_dlc   = '0;
    logic [63:0] tx_data  = '0;
    logic        CAN_RX   = 1'b1;
    logic        CAN_TX;
    logic        tx_busy;
    logic        tx_done;
    logic        ack_err;

    int checks = 0;
    int errors = 0;

    bit raw_q[$];
    bit exp_q[$];
    bit obs_q[$];
    bit dq[$];
    int exp_len;
    int busy_cycles;
    int stuff_cnt;
    int stuff_in_data;

    can_transmitter #(.IFS_BITS(IFS_BITS)) dut (
        .baud_clk(baud_clk), .reset(reset), .tx_start(tx_start), .tx_id(tx_id),
        .tx_rtr(tx_rtr), .tx_dlc(tx_dlc), .tx_data(tx_data), .CAN_RX(CAN_RX),
        .CAN_TX(CAN_TX), .tx_busy(tx_busy), .tx_done(tx_done), .ack_err(ack_err)
    );

    always #5 baud_clk = ~baud_clk;

    function automatic logic [14:0] crc_of(input bit bits[$], input int m);
        logic [14:0] c;
        bit nxt;
        c = '0;
        for (int i = 0; i < m; i++) begin
            nxt = bits[i] ^ c[14];
            c = {c[13:0], 1'b0};
            if (nxt) c = c ^ 15'h4599;
        end
        return c;
    endfunction

    // Golden model: raw frame, CRC, then stuffing over SOF..CRC, then fixed recessive tail
    task automatic build_expected(input logic [10:0] id, input logic rtr,
                                  input logic [3:0] dlc, input logic [63:0] data);
        int n;
        int run;
        bit last;
        bit b;
        logic [14:0] crc;
        raw_q = {};
        exp_q = {};
        raw_q.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw_q.push_back(id[i]);
        raw_q.push_back(rtr);
        raw_q.push_back(1'b0);
        raw_q.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw_q.push_back(dlc[i]);
        n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int i = 0; i < 8 * n; i++) raw_q.push_back(data[63 - i]);
        crc = crc_of(raw_q, raw_q.size());
        for (int i = 14; i >= 0; i--) raw_q.push_back(crc[i]);
        run = 0;
        last = 1'b0;
        for (int i = 0; i < raw_q.size(); i++) begin
            b = raw_q[i];
            exp_q.push_back(b);
            if (run > 0 && b == last) run++;
            else begin
                run = 1;
                last = b;
            end
            if (run == 5) begin
                exp_q.push_back(!b);
                last = !b;
                run = 1;
            end
        end
        for (int i = 0; i < 10 + int'(IFS_BITS); i++) exp_q.push_back(1'b1);
        exp_len = exp_q.size();
    endtask

    // Removes stuff bits from the observed stream within the first 'region' raw bits
    task automatic destuff_obs(input int region, input int data_bits);
        int run;
        bit last;
        bit skip;
        bit b;
        dq = {};
        stuff_cnt = 0;
        stuff_in_data = 0;
        run = 0;
        last = 1'b0;
        skip = 1'b0;
        for (int i = 0; i < obs_q.size(); i++) begin
            b = obs_q[i];
            if (skip) begin
                skip = 1'b0;
                stuff_cnt++;
                if (dq.size() >= 20 && dq.size() <= 19 + data_bits) stuff_in_data++;
                last = b;
                run = 1;
            end else begin
                dq.push_back(b);
                if (dq.size() <= region) begin
                    if (run > 0 && b == last) run++;
                    else begin
                        run = 1;
                        last = b;
                    end
                    if (run == 5) skip = 1'b1;
                end
            end
        end
    endtask

    task automatic run_frame(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                             input logic [63:0] data, input bit ack_given, input bit hold_start,
                             input string name);
        int ack_slot;
        bit exp_bit;
        logic exp_ae;
        build_expected(id, rtr, dlc, data);
        obs_q = {};
        busy_cycles = 0;
        ack_slot = exp_len - int'(IFS_BITS) - 9;
        @(negedge baud_clk);
        tx_id = id;
        tx_rtr = rtr;
        tx_dlc = dlc;
        tx_data = data;
        tx_start = 1'b1;
        CAN_RX = ack_given;
        for (int k = 0; k < exp_len + 2; k++) begin
            @(negedge baud_clk);
            if (k == 0 && !hold_start) begin
                tx_start = 1'b0;
                tx_id = 11'($urandom);
                tx_rtr = 1'($urandom);
                tx_dlc = 4'($urandom);
                tx_data = {$urandom, $urandom};
            end
            if (k < exp_len) begin
                exp_bit = exp_q.pop_front();
                obs_q.push_back(CAN_TX);
                if (tx_busy) busy_cycles++;
                checks++;
                if (CAN_TX !== exp_bit) begin
                    errors++;
                    $display("FAIL %s bit %0d: CAN_TX=%b expected %b", name, k, CAN_TX, exp_bit);
                end
                exp_ae = (k == ack_slot + 1) && !ack_given;
                checks++;
                if (ack_err !== exp_ae) begin
                    errors++;
                    $display("FAIL %s ack_err cycle %0d: got %b expected %b", name, k, ack_err, exp_ae);
                end
                checks++;
                if (tx_done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early tx_done cycle %0d: got %b expected 0", name, k, tx_done);
                end
                CAN_RX = (k == ack_slot) ? !ack_given : ack_given;
            end else if (k == exp_len) begin
                checks++;
                if (tx_busy !== 1'b0 || tx_done !== 1'b1 || CAN_TX !== 1'b1) begin
                    errors++;
                    $display("FAIL %s idle entry: busy=%b done=%b tx=%b expected 0 1 1",
                             name, tx_busy, tx_done, CAN_TX);
                end
                checks++;
                if (busy_cycles != exp_len) begin
                    errors++;
                    $display("FAIL %s busy width: got %0d expected %0d", name, busy_cycles, exp_len);
                end
            end else if (hold_start) begin
                checks++;
                if (tx_done !== 1'b0 || CAN_TX !== 1'b0 || tx_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s restart: done=%b tx=%b busy=%b expected 0 0 1",
                             name, tx_done, CAN_TX, tx_busy);
                end
            end else begin
                checks++;
                if (tx_done !== 1'b0 || tx_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done width: done=%b busy=%b expected 0 0", name, tx_done, tx_busy);
                end
            end
        end
        CAN_RX = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tx_start = 1'b1;
        tx_id = 11'h2A5;
        tx_dlc = 4'd1;
        tx_data = 64'hC3 << 56;
        repeat (3) @(negedge baud_clk);
        checks++;
        if (CAN_TX !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 || ack_err !== 1'b0) begin
            errors++;
            $display("FAIL reset values: tx=%b busy=%b done=%b ack_err=%b expected 1 0 0 0",
                     CAN_TX, tx_busy, tx_done, ack_err);
        end
        reset = 1'b0;
        @(negedge baud_clk);
        checks++;
        if (CAN_TX !== 1'b0 || tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset release SOF: tx=%b busy=%b expected 0 1", CAN_TX, tx_busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (CAN_TX !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset abort: tx=%b busy=%b expected 1 0", CAN_TX, tx_busy);
        end
        tx_start = 1'b0;
        @(negedge baud_clk);
        reset = 1'b0;
    endtask

    task automatic test_zero_frame();
        logic [17:0] head;
        logic [17:0] gold;
        logic [14:0] got_crc;
        logic [14:0] ref_crc;
        run_frame(11'h000, 1'b0, 4'd0, 64'h0, 1'b1, 1'b0, "zero_frame");
        gold = 18'b000001000001000001;
        for (int i = 0; i < 18; i++) head[17 - i] = obs_q[i];
        checks++;
        if (head !== gold) begin
            errors++;
            $display("FAIL zero_frame stuff pattern: got %b expected %b", head, gold);
        end
        destuff_obs(34, 0);
        for (int i = 0; i < 15; i++) got_crc[14 - i] = dq[19 + i];
        ref_crc = crc_of(dq, 19);
        checks++;
        if (got_crc !== ref_crc) begin
            errors++;
            $display("FAIL zero_frame crc: got %h expected %h", got_crc, ref_crc);
        end
    endtask

    task automatic test_single_byte();
        int bad;
        logic [14:0] got_crc;
        logic [14:0] ref_crc;
        run_frame(11'h123, 1'b0, 4'd1, 64'hA5 << 56, 1'b1, 1'b0, "single_byte");
        destuff_obs(42, 8);
        bad = 0;
        for (int i = 0; i < 42; i++) if (dq[i] != raw_q[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL single_byte destuffed stream: %0d bits differ, expected 0", bad);
        end
        for (int i = 0; i < 15; i++) got_crc[14 - i] = dq[27 + i];
        ref_crc = crc_of(dq, 27);
        checks++;
        if (got_crc !== ref_crc) begin
            errors++;
            $display("FAIL single_byte crc: got %h expected %h", got_crc, ref_crc);
        end
        checks++;
        if (busy_cycles != 52 + int'(IFS_BITS) + stuff_cnt) begin
            errors++;
            $display("FAIL single_byte busy: got %0d expected %0d", busy_cycles,
                     52 + int'(IFS_BITS) + stuff_cnt);
        end
    endtask

    task automatic test_remote();
        logic [3:0] dlc_f;
        run_frame(11'h6E1, 1'b1, 4'd8, {$urandom, $urandom}, 1'b1, 1'b0, "remote");
        destuff_obs(34, 0);
        for (int i = 0; i < 4; i++) dlc_f[3 - i] = dq[15 + i];
        checks++;
        if (dlc_f !== 4'b1000) begin
            errors++;
            $display("FAIL remote dlc field: got %b expected 1000", dlc_f);
        end
        checks++;
        if (dq.size() != 44 + int'(IFS_BITS)) begin
            errors++;
            $display("FAIL remote length: got %0d expected %0d", dq.size(), 44 + int'(IFS_BITS));
        end
    endtask

    task automatic test_max_dlc();
        logic [3:0] dlc_f;
        int ones;
        run_frame(11'h0AA, 1'b0, 4'd15, {64{1'b1}}, 1'b1, 1'b0, "max_dlc");
        destuff_obs(98, 64);
        for (int i = 0; i < 4; i++) dlc_f[3 - i] = dq[15 + i];
        checks++;
        if (dlc_f !== 4'b1111) begin
            errors++;
            $display("FAIL max_dlc dlc field: got %b expected 1111", dlc_f);
        end
        ones = 0;
        for (int i = 19; i < 83; i++) if (dq[i]) ones++;
        checks++;
        if (ones != 64 || dq.size() != 108 + int'(IFS_BITS)) begin
            errors++;
            $display("FAIL max_dlc data: ones=%0d len=%0d expected 64 %0d", ones, dq.size(),
                     108 + int'(IFS_BITS));
        end
        checks++;
        if (stuff_in_data < 12) begin
            errors++;
            $display("FAIL max_dlc stuffing in data: got %0d expected at least 12", stuff_in_data);
        end
    endtask

    task automatic test_no_ack();
        run_frame(11'h3C5, 1'b0, 4'd3, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, "no_ack");
    endtask

    task automatic test_back_to_back();
        bit seen;
        run_frame(11'h701, 1'b0, 4'd2, 64'hF00F << 48, 1'b1, 1'b1, "back_to_back");
        tx_start = 1'b0;
        CAN_RX = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge baud_clk);
            if (tx_done) seen = 1'b1;
        end
        CAN_RX = 1'b1;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL back_to_back second frame: tx_done=0 expected 1 within 300 cycles");
        end
    endtask

    task automatic test_reset_mid_data();
        @(negedge baud_clk);
        tx_id = 11'h555;
        tx_rtr = 1'b0;
        tx_dlc = 4'd2;
        tx_data = 64'h3CA5 << 48;
        tx_start = 1'b1;
        @(negedge baud_clk);
        tx_start = 1'b0;
        repeat (24) @(negedge baud_clk);
        checks++;
        if (tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_data busy before reset: got %b expected 1", tx_busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (CAN_TX !== 1'b1 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_data abort: tx=%b busy=%b expected 1 0", CAN_TX, tx_busy);
        end
        @(negedge baud_clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge baud_clk);
            checks++;
            if (tx_done !== 1'b0 || tx_busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_data after abort: done=%b busy=%b expected 0 0", tx_done, tx_busy);
            end
        end
        run_frame(11'h18E, 1'b0, 4'd4, {$urandom, $urandom}, 1'b1, 1'b0, "after_abort");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero_frame();
        test_single_byte();
        test_remote();
        test_max_dlc();
        test_no_ack();
        test_back_to_back();
        test_reset_mid_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
